// File: rtl/upramp_sprite_fetch_pkg.sv
// Shared constants, palette-index type and sprite image for the upramp sprite fetch.
package upramp_sprite_fetch_pkg;

    localparam int SPRITE_W = 32;
    localparam int SPRITE_H = 32;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Coordinate width covers the larger screen dimension.
    localparam int COORD_W = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);
    localparam int X_OFF_W = $clog2(SPRITE_W);
    localparam int Y_OFF_W = $clog2(SPRITE_H);
    localparam int ROM_AW  = X_OFF_W + Y_OFF_W;

    // Magenta key entries: palette indices 1, 6, 10 and 11 are see-through.
    localparam logic [15:0] TRANSP_MASK = 16'h0C42;

    typedef logic [3:0] pal_idx_t;

    // Sprite image, one 4-bit palette index per texel, addressed {row, col}.
    // Regenerate the ROM image from this function when the artwork changes.
    function automatic pal_idx_t rom_word(input logic [ROM_AW-1:0] addr);
        return addr[3:0] ^ addr[7:4] ^ {2'b00, addr[9:8]};
    endfunction

endpackage

// File: rtl/upramp_rom.sv
// Sprite image ROM: 1024 x 4-bit, registered (1-cycle) synchronous read.
module upramp_rom
    import upramp_sprite_fetch_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output pal_idx_t          data
);

    // Registered read of the sprite image.
    always_ff @(posedge clk) begin
        data <= rom_word(addr);
    end

endmodule

// File: rtl/upramp_sprite_fetch.sv
// Sprite fetch for the upramp: box test, ROM address generation and 2-cycle
// palette-index pipeline. Define UPRAMP_FLIP_EN to add the horizontal mirror.
module upramp_sprite_fetch
    import upramp_sprite_fetch_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               pix_valid,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               pos_load,
`ifdef UPRAMP_FLIP_EN
    input  logic               flip,
`endif
    output pal_idx_t           index,
    output logic               hit,
    output logic               opaque,
    output logic               out_valid
);

    logic [COORD_W-1:0] pend_x, pend_y, act_x, act_y;
    logic [COORD_W:0]   dx, dy;
    logic [X_OFF_W-1:0] col;
    logic [ROM_AW-1:0]  rom_addr;
    logic               hit0, hit1, valid1;
    pal_idx_t           rom_data;

`ifdef UPRAMP_FLIP_EN
    logic pend_flip, act_flip;

    // Flip request follows the same pending/active handoff as the position.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend_flip <= 1'b0;
            act_flip  <= 1'b0;
        end else begin
            if (pos_load) pend_flip <= flip;
            if (frame_start) act_flip <= pos_load ? flip : pend_flip;
        end
    end
`endif

    // Pending position takes any load; active only changes at frame start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend_x <= '0;
            pend_y <= '0;
            act_x  <= '0;
            act_y  <= '0;
        end else begin
            if (pos_load) begin
                pend_x <= pos_x;
                pend_y <= pos_y;
            end
            if (frame_start) begin
                act_x <= pos_load ? pos_x : pend_x;
                act_y <= pos_load ? pos_y : pend_y;
            end
        end
    end

    // Stage 0: signed offsets into the box; negative or >= size means outside.
    always_comb begin
        dx   = {1'b0, DrawX} - {1'b0, act_x};
        dy   = {1'b0, DrawY} - {1'b0, act_y};
        hit0 = pix_valid & ~dx[COORD_W] & (dx[COORD_W-1:X_OFF_W] == '0)
                         & ~dy[COORD_W] & (dy[COORD_W-1:Y_OFF_W] == '0);
        col  = dx[X_OFF_W-1:0];
`ifdef UPRAMP_FLIP_EN
        if (act_flip) col = X_OFF_W'(SPRITE_W - 1) - dx[X_OFF_W-1:0];
`endif
        rom_addr = {dy[Y_OFF_W-1:0], col};
    end

    upramp_rom u_rom (
        .clk  (Clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // Stage 1: qualifiers travel alongside the ROM read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit1   <= 1'b0;
            valid1 <= 1'b0;
        end else begin
            hit1   <= hit0;
            valid1 <= pix_valid;
        end
    end

    // Stage 2: registered outputs; misses force index 0 and transparent.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            index     <= '0;
            hit       <= 1'b0;
            opaque    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            index     <= hit1 ? rom_data : '0;
            hit       <= hit1;
            opaque    <= hit1 & ~TRANSP_MASK[rom_data];
            out_valid <= valid1;
        end
    end

endmodule
